// File: rtl/glyph_blitter_if.sv
// rtl/glyph_blitter_if.sv - command, alphabet ROM and frame-buffer signals of the glyph blitter
interface glyph_blitter_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_letter;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [15:0] rom_addr;
    logic        rom_q;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic        fb_data;
    logic        busy;
    logic        done;

    modport master (
        output cmd_valid, cmd_letter, cmd_x, cmd_y, rom_q,
        input  cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_letter, cmd_x, cmd_y, rom_q,
        output cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/glyph_blitter.sv
// rtl/glyph_blitter.sv - copies one 50x50 ROM glyph into the 1-bit frame buffer, one pixel per clock
// Optional GLYPH_BLITTER_TRANSPARENT_EN: only pixels of value 1 are written.
module glyph_blitter #(
    parameter int GLYPH_W     = 50,
    parameter int GLYPH_H     = 50,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int NUM_LETTERS = 26,
    parameter int SPACE_CODE  = 31
) (
    input  logic           clk,
    input  logic           reset,
    glyph_blitter_if.slave bus
);
    localparam logic [4:0]  NUM_CODES  = 5'(NUM_LETTERS);
    localparam logic [4:0]  SPACE      = 5'(SPACE_CODE);
    localparam logic [5:0]  GX_LAST    = 6'(GLYPH_W - 1);
    localparam logic [5:0]  GY_LAST    = 6'(GLYPH_H - 1);
    localparam logic [10:0] COL_LIMIT  = 11'(SCREEN_W);
    localparam logic [9:0]  ROW_LIMIT  = 10'(SCREEN_H);
    localparam logic [18:0] PITCH      = 19'(SCREEN_W);
    localparam int          GLYPH_SIZE = GLYPH_W * GLYPH_H;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t      state, state_next;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic        space_q;
    logic [5:0]  gx, gy;
    logic [18:0] row_base;
    logic [15:0] rom_addr_q;
    logic [18:0] fb_addr_q;
    logic        wr_pend;
    logic        clip_q;
    logic        accept;
    logic        letter_ok;
    logic        last_pix;
    logic [10:0] col;
    logic [9:0]  row;

    assign accept    = (state == IDLE) && bus.cmd_valid;
    assign letter_ok = (bus.cmd_letter < NUM_CODES) || (bus.cmd_letter == SPACE);
    assign last_pix  = (gx == GX_LAST) && (gy == GY_LAST);
    assign col       = {1'b0, x_q} + {5'd0, gx};
    assign row       = {1'b0, y_q} + {4'd0, gy};

    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) state_next = letter_ok ? RUN : DONE;
            end
            RUN:     if (last_pix) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            space_q    <= 1'b0;
            gx         <= '0;
            gy         <= '0;
            row_base   <= '0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            wr_pend    <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            state   <= state_next;
            // The write for the pixel addressed this cycle lands next cycle, alongside rom_q.
            wr_pend <= (state == RUN);
            if (state == RUN) begin
                fb_addr_q  <= row_base + {8'd0, col};
                clip_q     <= (col >= COL_LIMIT) || (row >= ROW_LIMIT);
                rom_addr_q <= rom_addr_q + 16'd1;
                if (gx == GX_LAST) begin
                    gx       <= '0;
                    gy       <= gy + 6'd1;
                    row_base <= row_base + PITCH;
                end else begin
                    gx <= gx + 6'd1;
                end
            end
            if (accept) begin
                x_q        <= bus.cmd_x;
                y_q        <= bus.cmd_y;
                space_q    <= (bus.cmd_letter == SPACE);
                gx         <= '0;
                gy         <= '0;
                row_base   <= 19'(32'(bus.cmd_y) * SCREEN_W);
                rom_addr_q <= 16'(32'(bus.cmd_letter) * GLYPH_SIZE);
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = wr_pend & ~space_q & bus.rom_q;
`ifdef GLYPH_BLITTER_TRANSPARENT_EN
    assign bus.fb_we    = wr_pend & ~clip_q & bus.fb_data;
`else
    assign bus.fb_we    = wr_pend & ~clip_q;
`endif
endmodule

// File: tb/tb_glyph_blitter.sv
// tb/tb_glyph_blitter.sv - randomized-ROM bench for glyph_blitter against a per-pixel reference model
module tb_glyph_blitter;
    logic clk = 1'b0;
    logic reset;
    bit   rom [0:65535];
    int   n_checks = 0;
    int   n_fail = 0;

    glyph_blitter_if bus();

    glyph_blitter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the block idle.
    task automatic send(input int l, input int x, input int y);
        bus.cmd_letter = 5'(l);
        bus.cmd_x      = 10'(x);
        bus.cmd_y      = 9'(y);
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    function automatic bit pixel_written(input int l, input int x, input int y, input int k);
        int gx = k % 50;
        int gy = k / 50;
        bit on = (l == 31) ? 1'b0 : rom[(l * 2500 + k) & 16'hffff];
        bit vis = (x + gx < 640) && (y + gy < 480);
`ifdef GLYPH_BLITTER_TRANSPARENT_EN
        return vis && on;
`else
        return vis;
`endif
    endfunction

    function automatic int expected_writes(input int l, input int x, input int y);
        int n = 0;
        for (int k = 0; k < 2500; k++) n += pixel_written(l, x, y, k);
        return n;
    endfunction

    // Walks cycles 0..2502 after acceptance, comparing every output to the model.
    task automatic check_cmd(input string tag, input int l, input int x, input int y,
                             output int nw, output int first_addr, output int last_addr,
                             output int last_cyc);
        int  err = 0;
        int  k, ea;
        bit  ewe, ed;
        nw = 0; first_addr = -1; last_addr = -1; last_cyc = -1;
        for (int c = 0; c <= 2502; c++) begin
            @(negedge clk);
            if (c < 2500 && bus.rom_addr !== 16'((l * 2500 + c) & 16'hffff)) err++;
            ewe = 1'b0;
            if (c >= 1 && c <= 2500) begin
                k   = c - 1;
                ea  = (y + k / 50) * 640 + x + k % 50;
                ed  = (l == 31) ? 1'b0 : rom[(l * 2500 + k) & 16'hffff];
                ewe = pixel_written(l, x, y, k);
                if (ewe && (bus.fb_addr !== 19'(ea) || bus.fb_data !== ed)) err++;
            end
            if (bus.fb_we !== ewe) err++;
            if (bus.fb_we === 1'b1) begin
                if (nw == 0) first_addr = int'(bus.fb_addr);
                nw++;
                last_addr = int'(bus.fb_addr);
                last_cyc  = c;
            end
            if (bus.done !== (c == 2501)) err++;
            if (bus.busy !== (c <= 2501)) err++;
            if (bus.cmd_ready !== (c == 2502)) err++;
        end
        chk({tag, "_cycle_errors"}, err, 0);
        chk({tag, "_write_count"}, nw, expected_writes(l, x, y));
    endtask

    task automatic check_invalid(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_we"}, bus.fb_we, 0);
        chk({tag, "_ready_low"}, bus.cmd_ready, 0);
        @(negedge clk);
        chk({tag, "_ready_back"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        int nw, fa, la, lc, cnt, c, l, x, y;
        for (int i = 0; i < 65536; i++) rom[i] = 1'($urandom_range(0, 1));
        bus.cmd_valid = 1'b0; bus.cmd_letter = '0; bus.cmd_x = '0; bus.cmd_y = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_we", bus.fb_we, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        reset = 1'b0;

        send(7, 0, 0);
        check_cmd("h_origin", 7, 0, 0, nw, fa, la, lc);
`ifndef GLYPH_BLITTER_TRANSPARENT_EN
        chk("h_first_addr", fa, 0);
        chk("h_last_addr", la, 31409);
        chk("h_last_cycle", lc, 2500);
        chk("h_writes", nw, 2500);
`endif

        send(2, 620, 100);
        check_cmd("clip_right", 2, 620, 100, nw, fa, la, lc);
`ifndef GLYPH_BLITTER_TRANSPARENT_EN
        chk("clip_first_addr", fa, 64620);
        chk("clip_writes", nw, 1000);
`endif

        send(28, 5, 5);
        check_invalid("inv28");
        send(29, 300, 300);
        check_invalid("inv29");

        send(31, 200, 200);
        check_cmd("space", 31, 200, 200, nw, fa, la, lc);
`ifdef GLYPH_BLITTER_TRANSPARENT_EN
        chk("space_writes", nw, 0);
`else
        chk("space_writes", nw, 2500);
`endif

        for (int r = 0; r < 4; r++) begin
            l = $urandom_range(0, 25);
            x = (r == 3) ? 1000 : $urandom_range(0, 700);
            y = $urandom_range(0, 500);
            send(l, x, y);
            check_cmd($sformatf("rand%0d", r), l, x, y, nw, fa, la, lc);
        end

        send(7, 0, 0);
        for (c = 0; c < 1000; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", bus.cmd_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_we", bus.fb_we, 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.fb_we !== 1'b0 || bus.done !== 1'b0) cnt++;
        end
        chk("midrst_quiet", cnt, 0);

        bus.cmd_letter = 5'd1; bus.cmd_x = '0; bus.cmd_y = '0;
        bus.cmd_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0; reset = 1'b0;
        chk("rstvalid_busy", bus.busy, 0);
        @(negedge clk);
        chk("rstvalid_idle", bus.busy, 0);

        bus.cmd_letter = 5'd3; bus.cmd_x = 10'd10; bus.cmd_y = 9'd20; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_letter = 5'd4; bus.cmd_x = 10'd30; bus.cmd_y = 9'd40;
        for (c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 0) chk("b2b_ignored_input", bus.rom_addr, 7500);
            if (bus.cmd_ready === 1'b1) break;
        end
        chk("b2b_accept_cycle", c, 2502);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        check_cmd("b2b_second", 4, 30, 40, nw, fa, la, lc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/glyph_blitter.md
Name: glyph_blitter

Overview:
- Writer-side counterpart of the letter pixel renderer. Accepts one letter command (code, screen x, screen y) and copies that 50x50 glyph from the alphabet ROM into the 1-bit 640x480 frame-buffer RAM, one pixel per clock.
- Used by the game-text controller to place "GET READY", "TIME IS UP" and "HOUSE CUP" strings one letter per command.

Parameters:
- GLYPH_W, 50, glyph width in pixels
- GLYPH_H, 50, glyph height in pixels
- SCREEN_W, 640, frame-buffer line pitch and horizontal clip limit
- SCREEN_H, 480, vertical clip limit
- NUM_LETTERS, 26, valid letter codes are 0..NUM_LETTERS-1
- SPACE_CODE, 31, letter code that erases the glyph cell

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_letter  in  5  letter code
- cmd_x  in  10  screen column of the glyph's top-left pixel
- cmd_y  in  9  screen row of the glyph's top-left pixel
- rom_addr  out  16  alphabet ROM address: letter*2500 + gy*50 + gx
- rom_q  in  1  ROM data, valid one cycle after rom_addr
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  19  frame-buffer address: (y+gy)*SCREEN_W + (x+gx)
- fb_data  out  1  pixel value to write
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted on an edge where cmd_valid && cmd_ready. The block latches letter, x and y.
  - Valid letter (< NUM_LETTERS) or SPACE_CODE: go to RUN.
  - Any other code: go to DONE and make no writes. done is high in the cycle after acceptance.
- RUN:
  - Cycle k after acceptance (k = 0..2499) drives rom_addr for pixel k.
  - Pixel order is raster: gx = k mod 50, gy = k div 50.
  - Addresses come from counters, with no per-pixel multiply. The ROM base letter*2500 is registered at acceptance. The fb row base starts at y*SCREEN_W and adds SCREEN_W at each gx wrap, i.e. 49 -> 0.
  - After pixel 2499, go to FLUSH.
- Write pipeline: fb_addr, fb_we and fb_data for pixel k are valid in cycle k+1. fb_data = rom_q, or 0 for SPACE_CODE.
- FLUSH: one cycle that performs the final write (pixel 2499, cycle 2500). Then go to DONE.
- DONE: done=1 for exactly one cycle, cmd_ready=0. Then go to IDLE.
- Command timing:
  - Total length is 2502 cycles from acceptance to cmd_ready rising again.
  - busy=1 in every cycle where state != IDLE.
  - A new command can be accepted in the first IDLE cycle.
- Clipping:
  - If x+gx >= SCREEN_W or y+gy >= SCREEN_H, fb_we=0 for that pixel.
  - Clipped pixels still use their cycle, so timing is unchanged.
  - Sums are computed 11 and 10 bits wide, so nothing wraps.
- cmd_* inputs are ignored while busy.
- Reset in mid-command: the state returns to IDLE at that edge. fb_we=0 from the next cycle, with no further writes and no done pulse.
- reset and cmd_valid in the same cycle: reset wins and the command is not accepted.

Optional Feature:
- Macro: GLYPH_BLITTER_TRANSPARENT_EN.
- Defined:
  - fb_we is also gated by the pixel value, so only pixels with value 1 are written and the background is preserved.
  - SPACE_CODE commands perform no writes but keep the same timing and done pulse.
- Undefined: every unclipped pixel is written with either 0 or 1, so the glyph cell is opaque.

Test Plan:
- Reset: assert reset for 2 cycles -> cmd_ready=1, busy=0, done=0, fb_we=0, rom_addr=0.
- Letter H at the origin: letter=7, x=0, y=0.
  - Cycle 0 after accept: rom_addr=17500.
  - Cycle 1: fb_we=1, fb_addr=0.
  - Pixel 50: rom_addr=17550, fb_addr=640.
  - Last write: fb_addr=31409 in cycle 2500. done in cycle 2501.
- Right-edge clip: letter=2, x=620, y=100.
  - Pixels gx=0..19 are written, fb_addr 64620..64639 for row 0.
  - gx >= 20 has fb_we=0. Total write count = 1000.
- Invalid and space codes:
  - letter=28: no fb_we at all, done in cycle 1 after accept.
  - SPACE_CODE at (200,200), macro undefined: 2500 writes, all fb_data=0.
- Reset mid-operation: assert reset at cycle 1000 of a command -> no fb_we afterwards, no done pulse, cmd_ready=1 on the next cycle.
- Back-to-back and transparency:
  - Second command held valid during the first -> accepted exactly 2502 cycles after the first.
  - With GLYPH_BLITTER_TRANSPARENT_EN defined, write count equals the number of 1s in the glyph.
